// File: rtl/mxint_quantizer_stream_if.sv
// Stream bundle for the MXINT quantizer: a fixed-point input block and
// an MXINT output block (shared exponent plus mantissas), each with valid/ready.
interface mxint_quantizer_stream_if #(
    parameter int IN_WIDTH   = 8,
    parameter int MAN_WIDTH  = 8,
    parameter int EXP_WIDTH  = 4,
    parameter int BLOCK_SIZE = 4
);
    logic signed [IN_WIDTH-1:0]  data_in   [BLOCK_SIZE];
    logic                        data_in_valid;
    logic                        data_in_ready;
    logic signed [MAN_WIDTH-1:0] mdata_out [BLOCK_SIZE];
    logic        [EXP_WIDTH-1:0] edata_out;
    logic                        data_out_valid;
    logic                        data_out_ready;

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, mdata_out, edata_out, data_out_valid
    );

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, mdata_out, edata_out, data_out_valid
    );
endinterface

// File: rtl/mxint_quantizer_stream.sv
// Two-stage streaming encoder: signed fixed-point blocks in, MXINT blocks
// (one clamped biased exponent plus saturated signed mantissas) out.
module mxint_quantizer_stream #(
    parameter int IN_WIDTH      = 8,
    parameter int IN_FRAC_WIDTH = 4,
    parameter int MAN_WIDTH     = 8,
    parameter int EXP_WIDTH     = 4,
    parameter int BLOCK_SIZE    = 4
) (
    input logic clk,
    input logic rst,
    mxint_quantizer_stream_if.slave bus
);
    localparam int BIAS  = 2**(EXP_WIDTH-1) - 1;
    localparam int E_MAX = 2**EXP_WIDTH - 1;
    // Largest left shift is MAN_WIDTH-2+BIAS-IN_FRAC_WIDTH; this width holds it unsaturated.
    localparam int SHW   = IN_WIDTH + MAN_WIDTH + 2**EXP_WIDTH + 1;
    localparam logic signed [SHW-1:0] SAT_HI = SHW'(2**(MAN_WIDTH-1) - 1);
    localparam logic signed [SHW-1:0] SAT_LO = ~SAT_HI;

    logic                        s1_valid;
    logic signed [IN_WIDTH-1:0]  s1_data [BLOCK_SIZE];
    logic        [EXP_WIDTH-1:0] s1_exp;
    logic                        s2_valid;
    logic signed [MAN_WIDTH-1:0] mdata_q [BLOCK_SIZE];
    logic        [EXP_WIDTH-1:0] edata_q;

    logic s2_load;
    logic s1_load;

    assign s2_load = !s2_valid || bus.data_out_ready;
    assign s1_load = !s1_valid || s2_load;

    assign bus.data_in_ready  = s1_load;
    assign bus.data_out_valid = s2_valid;
    assign bus.mdata_out      = mdata_q;
    assign bus.edata_out      = edata_q;

    // Stage 1: shared exponent from the leading one of the block magnitudes.
    logic [IN_WIDTH-1:0]  abs_or;
    logic [EXP_WIDTH-1:0] exp_next;
    int                   msb_idx;
    int                   e_biased;

    always_comb begin
        abs_or = '0;
        // The OR of all magnitudes has the same MSB as their maximum.
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            abs_or = abs_or | (bus.data_in[i][IN_WIDTH-1] ? -bus.data_in[i] : bus.data_in[i]);
        end
        msb_idx = 0;
        for (int unsigned b = 0; b < IN_WIDTH; b++) begin
            if (abs_or[b]) msb_idx = int'(b);
        end
        e_biased = msb_idx - IN_FRAC_WIDTH + BIAS;
        if (abs_or == '0)          exp_next = '0;
        else if (e_biased < 0)     exp_next = '0;
        else if (e_biased > E_MAX) exp_next = EXP_WIDTH'(E_MAX);
        else                       exp_next = EXP_WIDTH'(e_biased);
    end

    // Stage 2: align every element to the shared exponent, then saturate.
    int                          shift;
    logic signed [SHW-1:0]       ext     [BLOCK_SIZE];
    logic signed [SHW-1:0]       shifted [BLOCK_SIZE];
    logic signed [MAN_WIDTH-1:0] mant    [BLOCK_SIZE];

    always_comb begin
        shift = (MAN_WIDTH - 2) - (int'(s1_exp) - BIAS + IN_FRAC_WIDTH);
        for (int unsigned i = 0; i < BLOCK_SIZE; i++) begin
            ext[i] = {{(SHW-IN_WIDTH){s1_data[i][IN_WIDTH-1]}}, s1_data[i]};
            if (shift >= 0) shifted[i] = ext[i] <<< shift;
            else            shifted[i] = ext[i] >>> (-shift);
            if (shifted[i] > SAT_HI)      mant[i] = SAT_HI[MAN_WIDTH-1:0];
            else if (shifted[i] < SAT_LO) mant[i] = SAT_LO[MAN_WIDTH-1:0];
            else                          mant[i] = shifted[i][MAN_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            edata_q  <= '0;
            for (int unsigned i = 0; i < BLOCK_SIZE; i++) mdata_q[i] <= '0;
        end else begin
            if (s2_load) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    mdata_q <= mant;
                    edata_q <= s1_exp;
                end
            end
            if (s1_load) begin
                s1_valid <= bus.data_in_valid;
                if (bus.data_in_valid) begin
                    s1_data <= bus.data_in;
                    s1_exp  <= exp_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_mxint_quantizer_stream.sv
// Directed bench for mxint_quantizer_stream: hand-computed MXINT blocks,
// clamp/saturation instance, backpressure, throughput and mid-stream reset.
module tb_mxint_quantizer_stream;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mxint_quantizer_stream_if #(.IN_WIDTH(8), .MAN_WIDTH(8), .EXP_WIDTH(4), .BLOCK_SIZE(4)) bus ();
    mxint_quantizer_stream_if #(.IN_WIDTH(8), .MAN_WIDTH(8), .EXP_WIDTH(2), .BLOCK_SIZE(4)) bus_c ();

    mxint_quantizer_stream #(
        .IN_WIDTH(8), .IN_FRAC_WIDTH(4), .MAN_WIDTH(8), .EXP_WIDTH(4), .BLOCK_SIZE(4)
    ) dut (.clk(clk), .rst(rst), .bus(bus));

    mxint_quantizer_stream #(
        .IN_WIDTH(8), .IN_FRAC_WIDTH(0), .MAN_WIDTH(8), .EXP_WIDTH(2), .BLOCK_SIZE(4)
    ) dut_clamp (.clk(clk), .rst(rst), .bus(bus_c));

    int bp_in [10][4] = '{
        '{16, -8, 4, 0}, '{1, 0, 0, 0}, '{-128, -3, 3, 5}, '{0, 0, 0, 0},
        '{32, 16, -16, 8}, '{3, -3, 2, 1}, '{127, -1, 64, 5}, '{-3, 100, 7, -100},
        '{-1, -1, -1, -1}, '{-127, 2, -2, 1}};
    int bp_m [10][4] = '{
        '{64, -32, 16, 0}, '{64, 0, 0, 0}, '{-64, -2, 1, 2}, '{0, 0, 0, 0},
        '{64, 32, -32, 16}, '{96, -96, 64, 32}, '{127, -1, 64, 5}, '{-3, 100, 7, -100},
        '{-64, -64, -64, -64}, '{-127, 2, -2, 1}};
    int bp_e [10] = '{7, 3, 10, 0, 8, 4, 9, 9, 3, 9};
    logic [39:0] rdy_pat = 40'hB5_3C_96_E1_4D;

    task automatic drive_blk(input int a0, input int a1, input int a2, input int a3);
        bus.data_in[0] = 8'(a0);
        bus.data_in[1] = 8'(a1);
        bus.data_in[2] = 8'(a2);
        bus.data_in[3] = 8'(a3);
    endtask

    // Presents one block with ready high; returns at the negedge where the output is valid.
    task automatic send_block(input int a0, input int a1, input int a2, input int a3, output int lat);
        @(posedge clk); #1;
        drive_blk(a0, a1, a2, a3);
        bus.data_in_valid  = 1'b1;
        bus.data_out_ready = 1'b1;
        @(posedge clk); #1;
        bus.data_in_valid = 1'b0;
        lat = -1;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.data_out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.data_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid got %0b want 0", bus.data_out_valid);
        end
        checks++;
        if (bus_c.data_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_valid_clamp got %0b want 0", bus_c.data_out_valid);
        end
        checks++;
        if (bus.edata_out !== 4'd0) begin
            errors++; $display("FAIL reset_edata got %0d want 0", bus.edata_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.mdata_out[i] !== 8'sd0) begin
                errors++; $display("FAIL reset_mdata[%0d] got %0d want 0", i, bus.mdata_out[i]);
            end
        end
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_nominal;
        int lat;
        int em [4];
        em = '{64, -32, 16, 0};
        send_block(16, -8, 4, 0, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL nominal_latency got %0d want 2", lat);
        end
        checks++;
        if (bus.edata_out !== 4'd7) begin
            errors++; $display("FAIL nominal_edata got %0d want 7", bus.edata_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.mdata_out[i] !== 8'(em[i])) begin
                errors++; $display("FAIL nominal_mdata[%0d] got %0d want %0d", i, bus.mdata_out[i], em[i]);
            end
        end
    endtask

    task automatic test_most_negative;
        int lat;
        send_block(-128, 0, 0, 0, lat);
        checks++;
        if (bus.edata_out !== 4'd10) begin
            errors++; $display("FAIL mostneg_edata got %0d want 10", bus.edata_out);
        end
        checks++;
        if (bus.mdata_out[0] !== -8'sd64) begin
            errors++; $display("FAIL mostneg_mdata0 got %0d want -64", bus.mdata_out[0]);
        end
        send_block(-128, -3, 3, 5, lat);
        checks++;
        if (bus.mdata_out[1] !== -8'sd2 || bus.mdata_out[2] !== 8'sd1 || bus.mdata_out[3] !== 8'sd2) begin
            errors++;
            $display("FAIL floor_shift got %0d %0d %0d want -2 1 2",
                     bus.mdata_out[1], bus.mdata_out[2], bus.mdata_out[3]);
        end
    endtask

    task automatic test_small_input;
        int lat;
        send_block(1, 0, 0, 0, lat);
        checks++;
        if (bus.edata_out !== 4'd3) begin
            errors++; $display("FAIL small_edata got %0d want 3", bus.edata_out);
        end
        checks++;
        if (bus.mdata_out[0] !== 8'sd64) begin
            errors++; $display("FAIL small_mdata0 got %0d want 64", bus.mdata_out[0]);
        end
    endtask

    task automatic test_zero_block;
        int lat;
        send_block(0, 0, 0, 0, lat);
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL zero_latency got %0d want 2", lat);
        end
        checks++;
        if (bus.edata_out !== 4'd0) begin
            errors++; $display("FAIL zero_edata got %0d want 0", bus.edata_out);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.mdata_out[i] !== 8'sd0) begin
                errors++; $display("FAIL zero_mdata[%0d] got %0d want 0", i, bus.mdata_out[i]);
            end
        end
    endtask

    task automatic test_clamp;
        @(posedge clk); #1;
        bus_c.data_in[0] = 8'(127);
        bus_c.data_in[1] = 8'(0);
        bus_c.data_in[2] = 8'(0);
        bus_c.data_in[3] = 8'(0);
        bus_c.data_in_valid  = 1'b1;
        bus_c.data_out_ready = 1'b1;
        @(posedge clk); #1;
        bus_c.data_in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus_c.data_out_valid !== 1'b1) begin
            errors++; $display("FAIL clamp_valid got %0b want 1", bus_c.data_out_valid);
        end
        checks++;
        if (bus_c.edata_out !== 2'd3) begin
            errors++; $display("FAIL clamp_edata got %0d want 3", bus_c.edata_out);
        end
        checks++;
        if (bus_c.mdata_out[0] !== 8'sd127) begin
            errors++; $display("FAIL clamp_mdata0 got %0d want 127", bus_c.mdata_out[0]);
        end
    endtask

    task automatic test_backpressure;
        int sent = 0;
        int recv = 0;
        int occ = 0;
        logic rdy;
        logic exp_rdy;
        logic held = 1'b0;
        logic signed [7:0] prev_m [4];
        logic [3:0] prev_e = '0;
        for (int c = 0; c < 200 && recv < 10; c++) begin
            @(posedge clk); #1;
            rdy = rdy_pat[c % 40];
            bus.data_out_ready = rdy;
            if (sent < 10) begin
                drive_blk(bp_in[sent][0], bp_in[sent][1], bp_in[sent][2], bp_in[sent][3]);
                bus.data_in_valid = 1'b1;
            end else begin
                bus.data_in_valid = 1'b0;
            end
            @(negedge clk);
            exp_rdy = !(occ == 2 && !rdy);
            checks++;
            if (bus.data_in_ready !== exp_rdy) begin
                errors++; $display("FAIL bp_in_ready cycle %0d got %0b want %0b", c, bus.data_in_ready, exp_rdy);
            end
            if (held) begin
                checks++;
                if (bus.data_out_valid !== 1'b1 || bus.edata_out !== prev_e || bus.mdata_out !== prev_m) begin
                    errors++; $display("FAIL bp_stall_hold cycle %0d got valid %0b e %0d want held e %0d",
                                       c, bus.data_out_valid, bus.edata_out, prev_e);
                end
            end
            held   = bus.data_out_valid && !rdy;
            prev_m = bus.mdata_out;
            prev_e = bus.edata_out;
            if (bus.data_out_valid && rdy) begin
                checks++;
                if (bus.edata_out !== 4'(bp_e[recv]) || bus.mdata_out[0] !== 8'(bp_m[recv][0]) ||
                    bus.mdata_out[1] !== 8'(bp_m[recv][1]) || bus.mdata_out[2] !== 8'(bp_m[recv][2]) ||
                    bus.mdata_out[3] !== 8'(bp_m[recv][3])) begin
                    errors++;
                    $display("FAIL bp_block%0d got e%0d [%0d %0d %0d %0d] want e%0d [%0d %0d %0d %0d]", recv,
                             bus.edata_out, bus.mdata_out[0], bus.mdata_out[1], bus.mdata_out[2], bus.mdata_out[3],
                             bp_e[recv], bp_m[recv][0], bp_m[recv][1], bp_m[recv][2], bp_m[recv][3]);
                end
                recv++;
                occ--;
            end
            if (bus.data_in_valid && bus.data_in_ready) begin
                sent++;
                occ++;
            end
        end
        checks++;
        if (recv != 10) begin
            errors++; $display("FAIL bp_timeout got %0d blocks want 10", recv);
        end
        @(posedge clk); #1;
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b1;
    endtask

    task automatic test_full_throughput;
        logic want_v;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            bus.data_out_ready = 1'b1;
            if (c < 20) begin
                drive_blk(16, c, 0, 0);
                bus.data_in_valid = 1'b1;
            end else begin
                bus.data_in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 20) begin
                checks++;
                if (bus.data_in_ready !== 1'b1) begin
                    errors++; $display("FAIL tput_in_ready cycle %0d got %0b want 1", c, bus.data_in_ready);
                end
            end
            want_v = (c >= 2 && c < 22);
            checks++;
            if (bus.data_out_valid !== want_v) begin
                errors++; $display("FAIL tput_valid cycle %0d got %0b want %0b", c, bus.data_out_valid, want_v);
            end
            if (want_v) begin
                checks++;
                if (bus.mdata_out[1] !== 8'(4 * (c - 2)) || bus.mdata_out[0] !== 8'sd64 || bus.edata_out !== 4'd7) begin
                    errors++; $display("FAIL tput_data cycle %0d got m1 %0d m0 %0d e %0d want m1 %0d m0 64 e 7",
                                       c, bus.mdata_out[1], bus.mdata_out[0], bus.edata_out, 4 * (c - 2));
                end
            end
        end
    endtask

    task automatic test_reset_midstream;
        int lat = -1;
        @(posedge clk); #1;
        drive_blk(32, 0, 0, 0);
        bus.data_in_valid  = 1'b1;
        bus.data_out_ready = 1'b0;
        @(posedge clk); #1;
        drive_blk(-64, 16, 0, 0);
        @(posedge clk); #1;
        bus.data_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.data_out_valid !== 1'b1 || bus.data_in_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_full got valid %0b ready %0b want 1 0", bus.data_out_valid, bus.data_in_ready);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        drive_blk(-8, 4, 2, 1);
        bus.data_in_valid  = 1'b1;
        bus.data_out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.data_out_valid !== 1'b0 || bus.edata_out !== 4'd0 || bus.mdata_out[0] !== 8'sd0) begin
            errors++; $display("FAIL midrst_cleared got valid %0b e %0d m0 %0d want 0 0 0",
                               bus.data_out_valid, bus.edata_out, bus.mdata_out[0]);
        end
        @(posedge clk); #1;
        bus.data_in_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.data_out_valid) begin
                lat = c;
                break;
            end
            @(posedge clk); #1;
        end
        checks++;
        if (lat !== 2) begin
            errors++; $display("FAIL midrst_latency got %0d want 2", lat);
        end
        checks++;
        if (bus.edata_out !== 4'd6 || bus.mdata_out[0] !== -8'sd64 || bus.mdata_out[1] !== 8'sd32 ||
            bus.mdata_out[2] !== 8'sd16 || bus.mdata_out[3] !== 8'sd8) begin
            errors++; $display("FAIL midrst_first_block got e%0d [%0d %0d %0d %0d] want e6 [-64 32 16 8]",
                               bus.edata_out, bus.mdata_out[0], bus.mdata_out[1], bus.mdata_out[2], bus.mdata_out[3]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        drive_blk(0, 0, 0, 0);
        bus.data_in_valid  = 1'b0;
        bus.data_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) bus_c.data_in[i] = '0;
        bus_c.data_in_valid  = 1'b0;
        bus_c.data_out_ready = 1'b1;

        test_reset();
        test_nominal();
        test_most_negative();
        test_small_input();
        test_zero_block();
        test_clamp();
        test_backpressure();
        test_full_throughput();
        test_reset_midstream();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
